// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage-register enables, flushes and bubbles for the
// 5-stage core, plus a data-memory watchdog and a stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned TIMEOUT      = 64,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       ifid_rs,
   input  logic [2:0]       ifid_rt,
   input  logic             ifid_useRs,
   input  logic             ifid_useRt,
   input  logic             id_halt,
   input  logic             idex_memRead,
   input  logic             idex_regWrite,
   input  logic [2:0]       idex_writereg,
   input  logic             ex_redirect,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             idexBubble,
   output logic             pipeWrite,
   output logic             memwbBubble,
   output logic             haltDone,
   output logic             err,
   output logic [CNT_W-1:0] stallCycles
);

   localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned DrW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {StRun, StDrain, StHalted, StError} state_e;

   state_e           state_q, state_d;
   logic [DrW-1:0]   drain_q, drain_d;
   logic [WdW-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             load_use;
   logic             stall_inc;

   assign load_use = idex_memRead & idex_regWrite &
                     ((ifid_useRs & (ifid_rs == idex_writereg)) |
                      (ifid_useRt & (ifid_rt == idex_writereg)));

   always_comb begin
      pcWrite     = 1'b1;
      ifidWrite   = 1'b1;
      ifidFlush   = 1'b0;
      idexBubble  = 1'b0;
      pipeWrite   = 1'b1;
      memwbBubble = 1'b0;
      state_d     = state_q;
      drain_d     = drain_q;
      wd_d        = '0;

      case (state_q)
         StRun: begin
            if (dmem_stall) begin
               pcWrite     = 1'b0;
               ifidWrite   = 1'b0;
               pipeWrite   = 1'b0;
               memwbBubble = 1'b1;
               wd_d        = wd_q + WdW'(1);
               if (wd_d == WdW'(TIMEOUT)) state_d = StError;
            end else if (ex_redirect) begin
               // Redirect target is fetched; wrong-path instrs in IF and ID are squashed.
               ifidFlush  = 1'b1;
               idexBubble = 1'b1;
            end else if (load_use) begin
               pcWrite    = 1'b0;
               ifidWrite  = 1'b0;
               idexBubble = 1'b1;
            end else if (id_halt) begin
               pcWrite   = 1'b0;
               ifidFlush = 1'b1;
               state_d   = StDrain;
               drain_d   = DrW'(DRAIN_CYCLES);
            end else if (imem_stall) begin
               pcWrite   = 1'b0;
               ifidFlush = 1'b1;
            end
         end
         StDrain: begin
            pcWrite = 1'b0;
            if (dmem_stall) begin
               ifidWrite   = 1'b0;
               pipeWrite   = 1'b0;
               memwbBubble = 1'b1;
               wd_d        = wd_q + WdW'(1);
               if (wd_d == WdW'(TIMEOUT)) state_d = StError;
            end else begin
               ifidFlush  = 1'b1;
               idexBubble = 1'b1;
               // The last unfrozen drain cycle retires the halt from WB.
               if (drain_q <= DrW'(1)) begin
                  drain_d = '0;
                  state_d = StHalted;
               end else begin
                  drain_d = drain_q - DrW'(1);
               end
            end
         end
         default: begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            ifidFlush   = 1'b1;
            idexBubble  = 1'b1;
            pipeWrite   = 1'b0;
            memwbBubble = 1'b1;
         end
      endcase

      stall_inc = ((state_q == StRun) || (state_q == StDrain)) && !pcWrite;

      if (rst) begin
         pcWrite     = 1'b0;
         ifidWrite   = 1'b0;
         ifidFlush   = 1'b1;
         idexBubble  = 1'b1;
         pipeWrite   = 1'b0;
         memwbBubble = 1'b1;
         stall_inc   = 1'b0;
      end

      stall_d = (stall_inc && (stall_q != {CNT_W{1'b1}})) ? stall_q + CNT_W'(1) : stall_q;
   end

   assign haltDone    = !rst && (state_q == StHalted);
   assign err         = !rst && (state_q == StError);
   assign stallCycles = rst ? '0 : stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         drain_q <= '0;
         wd_q    <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         wd_q    <= wd_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for RUN priorities plus hand sequences
// for drain, watchdog and reset corner cases.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  ifid_rs, ifid_rt, idex_writereg;
   logic        ifid_useRs, ifid_useRt, id_halt, idex_memRead, idex_regWrite;
   logic        ex_redirect, imem_stall, dmem_stall;
   logic        pcWrite, ifidWrite, ifidFlush, idexBubble, pipeWrite, memwbBubble;
   logic        haltDone, err;
   logic [15:0] stallCycles;
   logic [5:0]  outs;

   int checks = 0;
   int errors = 0;
   int exp_stall;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .TIMEOUT(64), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .ifid_rs       (ifid_rs),
      .ifid_rt       (ifid_rt),
      .ifid_useRs    (ifid_useRs),
      .ifid_useRt    (ifid_useRt),
      .id_halt       (id_halt),
      .idex_memRead  (idex_memRead),
      .idex_regWrite (idex_regWrite),
      .idex_writereg (idex_writereg),
      .ex_redirect   (ex_redirect),
      .imem_stall    (imem_stall),
      .dmem_stall    (dmem_stall),
      .pcWrite       (pcWrite),
      .ifidWrite     (ifidWrite),
      .ifidFlush     (ifidFlush),
      .idexBubble    (idexBubble),
      .pipeWrite     (pipeWrite),
      .memwbBubble   (memwbBubble),
      .haltDone      (haltDone),
      .err           (err),
      .stallCycles   (stallCycles)
   );

   // {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeWrite, memwbBubble}
   assign outs = {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeWrite, memwbBubble};

   localparam logic [5:0] OutRun   = 6'b110010;
   localparam logic [5:0] OutDead  = 6'b001101;
   localparam logic [5:0] OutDrain = 6'b011110;

   typedef struct {
      logic [2:0] rs;
      logic [2:0] rt;
      logic       urs;
      logic       urt;
      logic       halt;
      logic       mrd;
      logic       rwr;
      logic [2:0] wreg;
      logic       redir;
      logic       imem;
      logic       dmem;
      logic [5:0] exp_outs;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      ifid_rs = '0; ifid_rt = '0; ifid_useRs = 0; ifid_useRt = 0; id_halt = 0;
      idex_memRead = 0; idex_regWrite = 0; idex_writereg = '0;
      ex_redirect = 0; imem_stall = 0; dmem_stall = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      ifid_rs = v.rs; ifid_rt = v.rt; ifid_useRs = v.urs; ifid_useRt = v.urt;
      id_halt = v.halt; idex_memRead = v.mrd; idex_regWrite = v.rwr;
      idex_writereg = v.wreg; ex_redirect = v.redir; imem_stall = v.imem;
      dmem_stall = v.dmem;
   endtask

   initial begin
      // rs, rt, useRs, useRt, halt, memRead, regWrite, writereg, redirect, imem, dmem, outs
      vecs[0]  = '{3'd0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 6'b110010};
      vecs[1]  = '{3'd0, 3'd3, 0, 1, 0, 1, 1, 3'd3, 0, 0, 0, 6'b000110};
      vecs[2]  = '{3'd0, 3'd3, 0, 0, 0, 1, 1, 3'd3, 0, 0, 0, 6'b110010};
      vecs[3]  = '{3'd3, 3'd0, 1, 0, 0, 1, 1, 3'd3, 0, 0, 0, 6'b000110};
      vecs[4]  = '{3'd3, 3'd3, 1, 1, 0, 1, 0, 3'd3, 0, 0, 0, 6'b110010};
      vecs[5]  = '{3'd3, 3'd3, 1, 1, 0, 0, 1, 3'd3, 0, 0, 0, 6'b110010};
      vecs[6]  = '{3'd3, 3'd5, 1, 1, 0, 1, 1, 3'd4, 0, 0, 0, 6'b110010};
      vecs[7]  = '{3'd0, 3'd3, 0, 1, 0, 1, 1, 3'd3, 1, 1, 0, 6'b111110};
      vecs[8]  = '{3'd0, 3'd3, 0, 1, 1, 1, 1, 3'd3, 1, 1, 0, 6'b111110};
      vecs[9]  = '{3'd0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 6'b011010};
      vecs[10] = '{3'd0, 3'd3, 0, 1, 0, 1, 1, 3'd3, 1, 1, 1, 6'b000001};
      vecs[11] = '{3'd0, 3'd3, 0, 1, 0, 1, 1, 3'd3, 0, 1, 0, 6'b000110};
      vecs[12] = '{3'd7, 3'd7, 1, 1, 0, 1, 1, 3'd7, 0, 0, 0, 6'b000110};
      vecs[13] = '{3'd0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 6'b110010};

      // Reset values while rst is held
      clear_inputs();
      rst = 1'b1;
      #1;
      check("rst_outs", outs, OutDead);
      check("rst_haltDone", haltDone, 0);
      check("rst_err", err, 0);
      check("rst_stallCycles", stallCycles, 0);

      // Free run, no hazards
      do_reset();
      for (int c = 0; c < 20; c++) begin
         #1;
         check($sformatf("free_c%0d", c), outs, OutRun);
         tick();
      end
      check("free_stallCycles", stallCycles, 0);

      // Vector table in RUN; halt with redirect must keep the state in RUN
      do_reset();
      exp_stall = 0;
      for (int i = 0; i < 14; i++) begin
         apply(vecs[i]);
         #1;
         check($sformatf("vec%0d", i), outs, vecs[i].exp_outs);
         if (!vecs[i].exp_outs[5]) exp_stall++;
         tick();
      end
      clear_inputs();
      #1;
      check("vec_stallCycles", stallCycles, exp_stall);
      check("vec_haltDone", haltDone, 0);

      // Single load-use stall
      do_reset();
      apply(vecs[1]);
      #1;
      check("lu_c0", outs, 6'b000110);
      tick();
      clear_inputs();
      #1;
      check("lu_c1", outs, OutRun);
      check("lu_stallCycles", stallCycles, 1);

      // Halt drain, no stalls
      do_reset();
      id_halt = 1'b1;
      #1;
      check("halt_c0", outs, 6'b011010);
      tick();
      id_halt = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         #1;
         check($sformatf("drain_c%0d", c), outs, OutDrain);
         check($sformatf("drain_hd_c%0d", c), haltDone, 0);
         tick();
      end
      #1;
      check("halted_c4", haltDone, 1);
      check("halted_outs", outs, OutDead);
      check("halted_stall", stallCycles, 4);
      tick();
      tick();
      check("halted_hold_hd", haltDone, 1);
      check("halted_hold_stall", stallCycles, 4);

      // Halt drain with a data-memory stall in cycle 2
      do_reset();
      id_halt = 1'b1;
      tick();
      id_halt = 1'b0;
      #1;
      check("dhalt_c1", outs, OutDrain);
      tick();
      dmem_stall = 1'b1;
      #1;
      check("dhalt_c2_pc", pcWrite, 0);
      check("dhalt_c2_pipe", pipeWrite, 0);
      check("dhalt_c2_memwb", memwbBubble, 1);
      tick();
      dmem_stall = 1'b0;
      for (int c = 3; c <= 4; c++) begin
         #1;
         check($sformatf("dhalt_c%0d", c), outs, OutDrain);
         check($sformatf("dhalt_hd_c%0d", c), haltDone, 0);
         tick();
      end
      #1;
      check("dhalt_c5_hd", haltDone, 1);

      // Reset in the middle of a drain
      do_reset();
      id_halt = 1'b1;
      tick();
      id_halt = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("mrst_outs", outs, OutDead);
      check("mrst_stall", stallCycles, 0);
      tick();
      rst = 1'b0;
      #1;
      check("mrst_run", outs, OutRun);
      check("mrst_hd", haltDone, 0);
      check("mrst_stall_after", stallCycles, 0);

      // Watchdog: 63 cycles is tolerated and clears, 64 is fatal
      do_reset();
      dmem_stall = 1'b1;
      for (int c = 0; c < 63; c++) begin
         #1;
         check($sformatf("wd63_c%0d", c), {memwbBubble, err}, 2'b10);
         tick();
      end
      dmem_stall = 1'b0;
      #1;
      check("wd63_release", outs, OutRun);
      check("wd63_err", err, 0);
      tick();
      dmem_stall = 1'b1;
      for (int c = 0; c < 64; c++) begin
         #1;
         check($sformatf("wd64_c%0d", c), err, 0);
         tick();
      end
      dmem_stall = 1'b0;
      #1;
      check("wd64_err", err, 1);
      check("wd64_hd", haltDone, 0);
      check("wd64_outs", outs, OutDead);
      tick();
      tick();
      check("wd64_err_hold", err, 1);
      rst = 1'b1;
      #1;
      check("wd_rst_err", err, 0);
      tick();
      rst = 1'b0;
      #1;
      check("wd_rst_run", outs, OutRun);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
